// File: rtl/pspi_pkg.sv
// Shared PSPI definitions used by both ends of the link.
// Holds the guest FSM encoding and the wire-level bit meanings.
package pspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDWR,
    ST_ADDR,
    ST_WDATA,
    ST_MEM,
    ST_MARK,
    ST_RDATA
  } pspi_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic WE_BIT    = 1'b1;

endpackage

// File: rtl/pspi_sync_edge.sv
// Brings the host sck/mosi into the guest clock domain.
// Produces one-cycle rise/fall strobes and delay-matched mosi.
module pspi_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_sck,
  input  logic [W-1:0] i_mosi,
  output logic         o_rise,
  output logic         o_fall,
  output logic [W-1:0] o_mosi
);

  logic         r_sck_s1;
  logic         r_sck_s2;
  logic         r_sck_d;
  logic [W-1:0] r_mosi_s1;
  logic [W-1:0] r_mosi_s2;

  // sck idles high, so the chain resets high to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s1  <= 1'b1;
      r_sck_s2  <= 1'b1;
      r_sck_d   <= 1'b1;
      r_mosi_s1 <= '1;
      r_mosi_s2 <= '1;
    end else begin
      r_sck_s1  <= i_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign o_rise = r_sck_s2 & ~r_sck_d;
  assign o_fall = ~r_sck_s2 & r_sck_d;
  assign o_mosi = r_mosi_s2;

endmodule

// File: rtl/pspi_guest.sv
// Guest end of the PSPI link: decodes one host transaction,
// performs one word access on the local memory port, replies on miso.
module pspi_guest
  import pspi_pkg::*;
#(
  parameter int          PSPI_WIDTH = 8,
  parameter logic [7:0]  DEV_ID     = 8'h01,
  parameter int          RST_EDGES  = 64,
  parameter logic [31:0] BAD_RDATA  = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic [PSPI_WIDTH-1:0] mosi,
  output logic [PSPI_WIDTH-1:0] miso,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [23:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  bus_rst,
  output logic                  id_err
);

  localparam int W   = PSPI_WIDTH;
  localparam int N   = 32 / W;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int RCW = $clog2(RST_EDGES + 1);

  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [RCW-1:0] RST_HIT  = RCW'(RST_EDGES - 1);
  localparam logic [RCW-1:0] RST_SAT  = RCW'(RST_EDGES);
  localparam logic [W-1:0]   MARKER   = {{(W-1){1'b1}}, 1'b0};

  logic         w_rise;
  logic         w_fall;
  logic [W-1:0] w_mosi;

  pspi_sync_edge #(
    .W (W)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sck  (sck),
    .i_mosi (mosi),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_mosi (w_mosi)
  );

  pspi_state_e    r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_we;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic [31:0]    r_rdata;
  logic           r_mark_ph;
  logic [RCW-1:0] r_rst_cnt;
  logic [W-1:0]   r_miso;
  logic           r_req;
  logic           r_bus_rst;
  logic           r_id_err;

  logic [31+W:0]  w_addr_cat;
  logic [31+W:0]  w_wdata_cat;
  logic [31+W:0]  w_rdata_cat;
  logic [31:0]    w_addr_sh;
  logic [31:0]    w_wdata_sh;
  logic [31:0]    w_rdata_sh;
  logic           w_rst_cnt_en;
  logic           w_bus_hit;

  // MSB-first shift; the concatenation keeps W == 32 legal
  assign w_addr_cat  = {r_addr, w_mosi};
  assign w_wdata_cat = {r_wdata, w_mosi};
  assign w_rdata_cat = {r_rdata, {W{1'b0}}};
  assign w_addr_sh   = w_addr_cat[31:0];
  assign w_wdata_sh  = w_wdata_cat[31:0];
  assign w_rdata_sh  = w_rdata_cat[31:0];

  assign w_rst_cnt_en = w_rise && (r_state != ST_MEM);
  assign w_bus_hit    = w_rst_cnt_en && w_mosi[0] && (r_rst_cnt == RST_HIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_mark_ph <= 1'b0;
      r_rst_cnt <= '0;
      r_miso    <= '1;
      r_req     <= 1'b0;
      r_bus_rst <= 1'b0;
      r_id_err  <= 1'b0;
    end else begin
      r_bus_rst <= 1'b0;
      r_id_err  <= 1'b0;

      // saturating run-length of ones; one pulse per run
      if (w_rst_cnt_en) begin
        if (!w_mosi[0]) begin
          r_rst_cnt <= '0;
        end else if (r_rst_cnt != RST_SAT) begin
          r_rst_cnt <= r_rst_cnt + RCW'(1);
        end
      end

      if (w_bus_hit) begin
        r_bus_rst <= 1'b1;
        r_miso    <= '1;
        r_mark_ph <= 1'b0;
        r_state   <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_rise && (w_mosi[0] == START_BIT)) begin
              r_state <= ST_RDWR;
            end
          end
          ST_RDWR: begin
            if (w_rise) begin
              r_we    <= (w_mosi[0] == WE_BIT);
              r_cnt   <= CNT_LAST;
              r_state <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_addr <= w_addr_sh;
              if (r_cnt == '0) begin
                r_cnt   <= CNT_LAST;
                r_state <= r_we ? ST_WDATA : ST_MEM;
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
          end
          ST_WDATA: begin
            if (w_rise) begin
              r_wdata <= w_wdata_sh;
              if (r_cnt == '0) begin
                r_state <= ST_MEM;
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
          end
          ST_MEM: begin
            if (!r_req) begin
              if (r_addr[31:24] != DEV_ID) begin
                r_id_err  <= 1'b1;
                r_rdata   <= BAD_RDATA;
                r_mark_ph <= 1'b0;
                r_state   <= ST_MARK;
              end else begin
                r_req <= 1'b1;
              end
            end else if (mem_ack) begin
              r_req <= 1'b0;
              if (!r_we) begin
                r_rdata <= mem_rdata;
              end
              r_mark_ph <= 1'b0;
              r_state   <= ST_MARK;
            end
          end
          ST_MARK: begin
            if (w_fall) begin
              if (!r_mark_ph) begin
                r_miso    <= MARKER;
                r_mark_ph <= 1'b1;
              end else begin
                r_mark_ph <= 1'b0;
                if (r_we) begin
                  r_miso  <= '1;
                  r_state <= ST_IDLE;
                end else begin
                  r_miso  <= r_rdata[31 -: W];
                  r_rdata <= w_rdata_sh;
                  r_cnt   <= CNT_LAST;
                  r_state <= ST_RDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            // the host takes the last chunk on this rise
            if (r_cnt == '0) begin
              if (w_rise) begin
                r_miso  <= '1;
                r_state <= ST_IDLE;
              end
            end else if (w_fall) begin
              r_miso  <= r_rdata[31 -: W];
              r_rdata <= w_rdata_sh;
              r_cnt   <= r_cnt - CW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign miso      = r_miso;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr[23:0];
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign bus_rst   = r_bus_rst;
  assign id_err    = r_id_err;

endmodule

// File: tb/tb_pspi_guest.sv
// Directed bench for pspi_guest with a 3-cycle-ack memory model.
// Acts as the PSPI host: drives sck/mosi, samples miso at edges.
module tb_pspi_guest;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic [7:0]  mosi = 8'hFF;
  logic [7:0]  miso;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        bus_rst;
  logic        id_err;

  int n_chk = 0;
  int n_fail = 0;
  int n_req = 0;
  int n_bus = 0;
  int n_id = 0;
  int ack_cnt = 0;
  logic        prev_req = 1'b0;
  logic        cap_we = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;

  always #5 clk = ~clk;

  pspi_guest #(
    .PSPI_WIDTH (8),
    .DEV_ID     (8'h01),
    .RST_EDGES  (64),
    .BAD_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .bus_rst   (bus_rst),
    .id_err    (id_err)
  );

  // memory model and pulse counters, all on the inactive edge
  always @(negedge clk) begin
    if (bus_rst) n_bus++;
    if (id_err) n_id++;
    if (mem_req && !prev_req) begin
      n_req++;
      cap_we = mem_we;
      cap_addr = mem_addr;
      cap_wdata = mem_wdata;
    end
    prev_req = mem_req;
    if (!rst_n) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic clk_bit(input logic [7:0] d,
                         output logic [7:0] sf,
                         output logic [7:0] sr);
    sf = miso;
    sck = 1'b0;
    mosi = d;
    half();
    sr = miso;
    sck = 1'b1;
    half();
  endtask

  task automatic send_hdr(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold_last);
    logic [7:0] sf, sr;
    logic [31:0] a, w;
    int nb;
    a = addr;
    w = wd;
    nb = we ? 10 : 6;
    clk_bit(8'h00, sf, sr);
    clk_bit({7'h7F, we}, sf, sr);
    for (int k = 2; k < nb; k++) begin
      logic [7:0] d;
      if (k < 6) begin
        d = a[31:24];
        a = a << 8;
      end else begin
        d = w[31:24];
        w = w << 8;
      end
      if (hold_last && k == nb - 1) begin
        sck = 1'b0;
        mosi = d;
        half();
        sck = 1'b1;
      end else begin
        clk_bit(d, sf, sr);
      end
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rword,
                      output bit mark_ok, output bit tail_ok);
    logic [7:0] sf, sr;
    send_hdr(we, addr, wd, 1'b0);
    mark_ok = 1'b0;
    rword = '0;
    sr = '0;
    for (int i = 0; i < 40; i++) begin
      clk_bit(8'hFF, sf, sr);
      if (sf == 8'hFE) begin
        mark_ok = 1'b1;
        break;
      end
    end
    if (we) begin
      tail_ok = (sr == 8'hFF);
      clk_bit(8'hFF, sf, sr);
      tail_ok = tail_ok && (sf == 8'hFF);
    end else begin
      rword[7:0] = sr;
      for (int k = 1; k < 4; k++) begin
        clk_bit(8'hFF, sf, sr);
        rword = {rword[23:0], sr};
      end
      clk_bit(8'hFF, sf, sr);
      tail_ok = (sf == 8'hFF);
    end
  endtask

  task automatic test_reset();
    n_chk++; if (miso !== 8'hFF) begin n_fail++; $display("FAIL reset_miso got %h want ff", miso); end
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_chk++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    n_chk++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (bus_rst !== 1'b0) begin n_fail++; $display("FAIL reset_bus_rst got %b want 0", bus_rst); end
    n_chk++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL reset_id_err got %b want 0", id_err); end
  endtask

  task automatic test_bus_reset();
    logic [7:0] sf, sr;
    int b0;
    b0 = n_bus;
    for (int i = 0; i < 256; i++) clk_bit(8'hFF, sf, sr);
    repeat (4) @(negedge clk);
    n_chk++; if (n_bus - b0 != 1) begin n_fail++; $display("FAIL busrst_pulses got %0d want 1", n_bus - b0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busrst_busy got %b want 0", busy); end
    n_chk++; if (miso !== 8'hFF) begin n_fail++; $display("FAIL busrst_miso got %h want ff", miso); end
  endtask

  task automatic test_write();
    logic [31:0] rw;
    bit mk, tl;
    int r0;
    r0 = n_req;
    xfer(1'b1, 32'h01000123, 32'h44332211, rw, mk, tl);
    n_chk++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL wr_reqs got %0d want 1", n_req - r0); end
    n_chk++; if (cap_we !== 1'b1) begin n_fail++; $display("FAIL wr_we got %b want 1", cap_we); end
    n_chk++; if (cap_addr !== 24'h000123) begin n_fail++; $display("FAIL wr_addr got %h want 000123", cap_addr); end
    n_chk++; if (cap_wdata !== 32'h44332211) begin n_fail++; $display("FAIL wr_wdata got %h want 44332211", cap_wdata); end
    n_chk++; if (!mk) begin n_fail++; $display("FAIL wr_marker got none want fe"); end
    n_chk++; if (!tl) begin n_fail++; $display("FAIL wr_tail got not-ff want ff"); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic [31:0] rw;
    bit mk, tl;
    int r0;
    r0 = n_req;
    mem_rdata = 32'hA1B2C3D4;
    xfer(1'b0, 32'h01000040, 32'h0, rw, mk, tl);
    n_chk++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL rd_reqs got %0d want 1", n_req - r0); end
    n_chk++; if (cap_we !== 1'b0) begin n_fail++; $display("FAIL rd_we got %b want 0", cap_we); end
    n_chk++; if (cap_addr !== 24'h000040) begin n_fail++; $display("FAIL rd_addr got %h want 000040", cap_addr); end
    n_chk++; if (!mk) begin n_fail++; $display("FAIL rd_marker got none want fe"); end
    n_chk++; if (rw !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL rd_word got %h want a1b2c3d4", rw); end
    n_chk++; if (!tl) begin n_fail++; $display("FAIL rd_tail got not-ff want ff"); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy got %b want 0", busy); end
  endtask

  task automatic test_id_mismatch();
    logic [31:0] rw;
    bit mk, tl;
    int r0, i0;
    r0 = n_req;
    i0 = n_id;
    mem_rdata = 32'h11111111;
    xfer(1'b0, 32'h02000000, 32'h0, rw, mk, tl);
    n_chk++; if (n_req - r0 != 0) begin n_fail++; $display("FAIL id_reqs got %0d want 0", n_req - r0); end
    n_chk++; if (n_id - i0 != 1) begin n_fail++; $display("FAIL id_pulses got %0d want 1", n_id - i0); end
    n_chk++; if (!mk) begin n_fail++; $display("FAIL id_marker got none want fe"); end
    n_chk++; if (rw !== 32'hDEADBEEF) begin n_fail++; $display("FAIL id_word got %h want deadbeef", rw); end
    n_chk++; if (!tl) begin n_fail++; $display("FAIL id_tail got not-ff want ff"); end
  endtask

  task automatic test_abort();
    logic [7:0] sf, sr;
    logic [31:0] rw;
    bit mk, tl;
    int r0, b0;
    r0 = n_req;
    b0 = n_bus;
    clk_bit(8'h00, sf, sr);
    for (int i = 0; i < 110; i++) clk_bit(8'hFF, sf, sr);
    repeat (4) @(negedge clk);
    n_chk++; if (n_req - r0 != 0) begin n_fail++; $display("FAIL abort_reqs got %0d want 0", n_req - r0); end
    n_chk++; if (n_bus - b0 != 1) begin n_fail++; $display("FAIL abort_busrst got %0d want 1", n_bus - b0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_chk++; if (miso !== 8'hFF) begin n_fail++; $display("FAIL abort_miso got %h want ff", miso); end
    r0 = n_req;
    xfer(1'b1, 32'h01000200, 32'h55AA0F0F, rw, mk, tl);
    n_chk++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL abort_wr_reqs got %0d want 1", n_req - r0); end
    n_chk++; if (cap_addr !== 24'h000200) begin n_fail++; $display("FAIL abort_wr_addr got %h want 000200", cap_addr); end
    n_chk++; if (cap_wdata !== 32'h55AA0F0F) begin n_fail++; $display("FAIL abort_wr_wdata got %h want 55aa0f0f", cap_wdata); end
    n_chk++; if (!(mk && tl)) begin n_fail++; $display("FAIL abort_wr_reply got %b%b want 11", mk, tl); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rw;
    bit mk, tl;
    bit got;
    int r0;
    send_hdr(1'b1, 32'h01000300, 32'h12345678, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req) begin
        got = 1'b1;
        break;
      end
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL arst_req_seen got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req got %b want 0", mem_req); end
    n_chk++; if (miso !== 8'hFF) begin n_fail++; $display("FAIL arst_miso got %h want ff", miso); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    r0 = n_req;
    mem_rdata = 32'h0BADF00D;
    xfer(1'b0, 32'h01000010, 32'h0, rw, mk, tl);
    n_chk++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL arst_rd_reqs got %0d want 1", n_req - r0); end
    n_chk++; if (cap_addr !== 24'h000010) begin n_fail++; $display("FAIL arst_rd_addr got %h want 000010", cap_addr); end
    n_chk++; if (rw !== 32'h0BADF00D) begin n_fail++; $display("FAIL arst_rd_word got %h want 0badf00d", rw); end
    n_chk++; if (!(mk && tl)) begin n_fail++; $display("FAIL arst_rd_reply got %b%b want 11", mk, tl); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_bus_reset();
    test_write();
    test_read();
    test_id_mismatch();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
